// File: rtl/pht_sat_tab_pkg.sv
//
// pht_sat_tab_pkg
// Shared definitions for the saturating-counter pattern history table:
//   - default geometry and init value for the table
//   - the two-state init/ready FSM encoding
//   - a helper that gives the width of the {tab,set} concatenated index
// No ports; imported by pht_sat_tab and sat_cnt_upd.
//
package pht_sat_tab_pkg;

   localparam int PHT_CNT_W_DEF    = 2;
   localparam int PHT_SET_W_DEF    = 4;
   localparam int PHT_TAB_W_DEF    = 6;
   localparam int PHT_INIT_VAL_DEF = 1;

   // ST_INIT sweeps the array one entry per cycle, ST_READY serves traffic
   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } phtState_e;

   // Width of the {tab,set} index used to address the counter array
   function automatic int phtIdxW(input int tabW, input int setW);
      return tabW + setW;
   endfunction

endpackage

// File: rtl/pht_sat_tab_sat_cnt_upd.sv
//
// sat_cnt_upd
// Combinational next-value logic for one saturating prediction counter.
// Counts up on taken, down on not-taken, and sticks at both ends instead
// of wrapping.
// Ports:
//   cnt       in   CNT_W  current counter value
//   taken     in   1      resolved branch direction
//   next_cnt  out  CNT_W  counter value after the update
//
module sat_cnt_upd
   import pht_sat_tab_pkg::*;
#(
   parameter int CNT_W = PHT_CNT_W_DEF
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             taken,
   output logic [CNT_W-1:0] next_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MIN = '0;

   // Move one step toward the resolved direction, holding at the rails
   always_comb begin
      next_cnt = cnt;
      if (taken) begin
         if (cnt != CNT_MAX) begin
            next_cnt = cnt + CNT_W'(1);
         end
      end else begin
         if (cnt != CNT_MIN) begin
            next_cnt = cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pht_sat_tab.sv
//
// pht_sat_tab
// Pattern history table of 2^(TAB_W+SET_W) saturating counters indexed by
// {tab,set}. After reset an init FSM sweeps INIT_VAL into every entry, one
// per cycle; during the sweep busy is high and all requests are dropped.
// Once ready, the table offers a registered read port (1-cycle latency) and
// a single-cycle read-modify-write update port.
//
// Configuration macro: PHT_WR_BYPASS_EN
//   defined   - a read and an update to the same entry in the same cycle
//               returns the post-update counter value
//   undefined - such a read returns the pre-update value
//
// Ports:
//   clk       in   1      clock, all logic on posedge
//   reset     in   1      synchronous active-high, restarts the init sweep
//   busy      out  1      high while the init sweep runs
//   rd_en     in   1      read request
//   rd_set    in   SET_W  read set index
//   rd_tab    in   TAB_W  read table index
//   rd_valid  out  1      one-cycle pulse when rd_data is fresh
//   rd_data   out  CNT_W  counter value read
//   rd_taken  out  1      predicted direction (counter MSB)
//   up_en     in   1      update request
//   up_set    in   SET_W  update set index
//   up_tab    in   TAB_W  update table index
//   up_taken  in   1      resolved branch direction
//
module pht_sat_tab
   import pht_sat_tab_pkg::*;
#(
   parameter int CNT_W    = PHT_CNT_W_DEF,
   parameter int SET_W    = PHT_SET_W_DEF,
   parameter int TAB_W    = PHT_TAB_W_DEF,
   parameter int INIT_VAL = PHT_INIT_VAL_DEF
) (
   input  logic             clk,
   input  logic             reset,
   output logic             busy,
   input  logic             rd_en,
   input  logic [SET_W-1:0] rd_set,
   input  logic [TAB_W-1:0] rd_tab,
   output logic             rd_valid,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_taken,
   input  logic             up_en,
   input  logic [SET_W-1:0] up_set,
   input  logic [TAB_W-1:0] up_tab,
   input  logic             up_taken
);

   localparam int              IDX_W    = phtIdxW(TAB_W, SET_W);
   localparam int              DEPTH    = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = '1;
   localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_VAL);

   phtState_e        state_q, state_d;
   logic [IDX_W-1:0] sweepPtr_q, sweepPtr_d;
   logic             rdValid_q, rdValid_d;
   logic [CNT_W-1:0] rdData_q, rdData_d;

   logic [CNT_W-1:0] mem [0:DEPTH-1];

   logic [IDX_W-1:0] rdIdx;
   logic [IDX_W-1:0] upIdx;
   logic             ready;
   logic             rdAccept;
   logic             upAccept;
   logic [CNT_W-1:0] rdCnt;
   logic [CNT_W-1:0] upCnt;
   logic [CNT_W-1:0] upNext;
   logic [CNT_W-1:0] rdSource;

   logic             wrEn;
   logic [IDX_W-1:0] wrAddr;
   logic [CNT_W-1:0] wrData;

   assign rdIdx    = {rd_tab, rd_set};
   assign upIdx    = {up_tab, up_set};
   assign ready    = (state_q == ST_READY);
   assign rdAccept = ready && rd_en;
   assign upAccept = ready && up_en;
   assign rdCnt    = mem[rdIdx];
   assign upCnt    = mem[upIdx];

   // Single counter-update instance; its result feeds both the array write
   // and, when enabled, the same-index read bypass
   sat_cnt_upd #(
      .CNT_W(CNT_W)
   ) uSatCntUpd (
      .cnt     (upCnt),
      .taken   (up_taken),
      .next_cnt(upNext)
   );

   // Pick what a read returns when it collides with an update to the same
   // entry: the freshly computed value or the stored one
`ifdef PHT_WR_BYPASS_EN
   assign rdSource = (upAccept && (upIdx == rdIdx)) ? upNext : rdCnt;
`else
   assign rdSource = rdCnt;
`endif

   // FSM next state and the shared array write port. In INIT the sweep owns
   // the port and walks sweepPtr up to the last entry; in READY the update
   // path owns it. A reset cycle writes nothing since the sweep restarts.
   always_comb begin
      state_d    = state_q;
      sweepPtr_d = sweepPtr_q;
      wrEn       = 1'b0;
      wrAddr     = upIdx;
      wrData     = upNext;
      case (state_q)
         ST_INIT: begin
            wrEn       = 1'b1;
            wrAddr     = sweepPtr_q;
            wrData     = INIT_CNT;
            sweepPtr_d = sweepPtr_q + IDX_W'(1);
            if (sweepPtr_q == LAST_IDX) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            wrEn = upAccept;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      if (reset) begin
         wrEn = 1'b0;
      end
   end

   // Read port next state: pulse valid only for accepted reads and keep the
   // last data otherwise
   always_comb begin
      rdValid_d = rdAccept;
      rdData_d  = rdData_q;
      if (rdAccept) begin
         rdData_d = rdSource;
      end
   end

   // Control and read-port registers; reset restarts the sweep from entry 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         sweepPtr_q <= '0;
         rdValid_q  <= 1'b0;
         rdData_q   <= '0;
      end else begin
         state_q    <= state_d;
         sweepPtr_q <= sweepPtr_d;
         rdValid_q  <= rdValid_d;
         rdData_q   <= rdData_d;
      end
   end

   // Counter array; contents are only meaningful after the sweep finishes
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign busy     = (state_q == ST_INIT);
   assign rd_valid = rdValid_q;
   assign rd_data  = rdData_q;
   assign rd_taken = rdData_q[CNT_W-1];

endmodule

// File: tb/tb_pht_sat_tab.sv
//
// tb_pht_sat_tab
// Self-checking bench for pht_sat_tab with a 16-entry table (TAB_W=2,
// SET_W=2, CNT_W=2, INIT_VAL=1). Expected read values are pushed into a
// scoreboard queue when a read is driven and popped when the read result
// is due; busy is tracked with a countdown of remaining sweep cycles.
//
module tb_pht_sat_tab;

   localparam int CNT_W    = 2;
   localparam int SET_W    = 2;
   localparam int TAB_W    = 2;
   localparam int INIT_VAL = 1;
   localparam int DEPTH    = 16;

`ifdef PHT_WR_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             busy;
   logic             rd_en;
   logic [SET_W-1:0] rd_set;
   logic [TAB_W-1:0] rd_tab;
   logic             rd_valid;
   logic [CNT_W-1:0] rd_data;
   logic             rd_taken;
   logic             up_en;
   logic [SET_W-1:0] up_set;
   logic [TAB_W-1:0] up_tab;
   logic             up_taken;

   int               total = 0;
   int               bad = 0;
   int               sweepLeft = 0;
   logic [CNT_W-1:0] expQ[$];

   typedef struct {
      bit rdEn;
      int rdIdx;
      bit upEn;
      int upIdx;
      bit upTaken;
      int expRd;
   } vec_t;

   vec_t satTab[$];

   pht_sat_tab #(
      .CNT_W   (CNT_W),
      .SET_W   (SET_W),
      .TAB_W   (TAB_W),
      .INIT_VAL(INIT_VAL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .busy    (busy),
      .rd_en   (rd_en),
      .rd_set  (rd_set),
      .rd_tab  (rd_tab),
      .rd_valid(rd_valid),
      .rd_data (rd_data),
      .rd_taken(rd_taken),
      .up_en   (up_en),
      .up_set  (up_set),
      .up_tab  (up_tab),
      .up_taken(up_taken)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: 4-state compare so X/Z outputs count as wrong
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
      end
   endtask

   // Drive one cycle of inputs, advance one clock, then check the outputs
   // that this cycle's edge produced
   task automatic applyStimulus(input bit rst, input bit rdEn, input int rdIdx,
                                input bit upEn, input int upIdx, input bit upTaken,
                                input int expRd);
      bit               accepted;
      logic [CNT_W-1:0] expVal;
      reset    = rst;
      rd_en    = rdEn;
      rd_tab   = TAB_W'(rdIdx >> SET_W);
      rd_set   = SET_W'(rdIdx);
      up_en    = upEn;
      up_tab   = TAB_W'(upIdx >> SET_W);
      up_set   = SET_W'(upIdx);
      up_taken = upTaken;
      accepted = !rst && (sweepLeft == 0);
      if (accepted && rdEn) begin
         expQ.push_back(CNT_W'(expRd));
      end
      if (rst) begin
         sweepLeft = DEPTH;
      end else if (sweepLeft > 0) begin
         sweepLeft--;
      end
      @(posedge clk);
      #1;
      checkOutput("busy", busy, sweepLeft > 0);
      checkOutput("rd_valid", rd_valid, accepted && rdEn);
      if (accepted && rdEn) begin
         expVal = expQ.pop_front();
         checkOutput("rd_data", rd_data, expVal);
         checkOutput("rd_taken", rd_taken, expVal[CNT_W-1]);
      end
      if (rst) begin
         checkOutput("rd_data_after_reset", rd_data, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      end
   endtask

   task automatic readEntry(input int idx, input int expRd);
      applyStimulus(1'b0, 1'b1, idx, 1'b0, 0, 1'b0, expRd);
   endtask

   task automatic updateEntry(input int idx, input bit taken);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, idx, taken, 0);
   endtask

   task automatic pulseReset();
      applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
   endtask

   initial begin
      reset    = 1'b0;
      rd_en    = 1'b0;
      rd_set   = '0;
      rd_tab   = '0;
      up_en    = 1'b0;
      up_set   = '0;
      up_tab   = '0;
      up_taken = 1'b0;

      // Entry 9 is {tab=2,set=1}: climb to 3 and stop, fall to 0 and stop;
      // then a read and update on different entries in the same cycle
      for (int i = 0; i < 4; i++) satTab.push_back('{0, 0, 1, 9, 1, 0});
      satTab.push_back('{1, 9, 0, 0, 0, 3});
      for (int i = 0; i < 5; i++) satTab.push_back('{0, 0, 1, 9, 0, 0});
      satTab.push_back('{1, 9, 0, 0, 0, 0});
      satTab.push_back('{1, 9, 1, 0, 1, 0});
      satTab.push_back('{1, 0, 0, 0, 0, 2});

      // Init: busy for exactly 16 cycles, then every entry holds 1
      pulseReset();
      idle(DEPTH);
      for (int i = 0; i < DEPTH; i++) readEntry(i, 1);
      idle(1);

      // Saturation and independent read/update
      foreach (satTab[i]) begin
         applyStimulus(1'b0, satTab[i].rdEn, satTab[i].rdIdx, satTab[i].upEn,
                       satTab[i].upIdx, satTab[i].upTaken, satTab[i].expRd);
      end
      idle(1);

      // Same-index collision on entry 7 (currently 1)
      applyStimulus(1'b0, 1'b1, 7, 1'b1, 7, 1'b1, BYPASS ? 2 : 1);
      readEntry(7, 2);
      idle(1);

      // Reset in READY after updates, with requests dropped during the sweep
      updateEntry(3, 1'b1);
      updateEntry(3, 1'b1);
      readEntry(3, 3);
      pulseReset();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 9 || i == DEPTH - 1) begin
            applyStimulus(1'b0, 1'b1, 5, 1'b1, 5, 1'b1, 0);
         end else begin
            idle(1);
         end
      end
      readEntry(3, 1);
      readEntry(5, 1);
      readEntry(7, 1);
      readEntry(9, 1);
      readEntry(0, 1);
      idle(1);

      // Reset mid-sweep: second reset on sweep cycle 9 restarts from 0
      updateEntry(14, 1'b1);
      updateEntry(14, 1'b1);
      updateEntry(2, 1'b0);
      pulseReset();
      idle(8);
      pulseReset();
      idle(DEPTH);
      for (int i = 0; i < DEPTH; i++) readEntry(i, 1);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
